// File: rtl/share_superalu.sv
// share_superalu: shared iterative multiply / restoring divide / CORDIC magnitude-phase unit.
// Build option: define SUPERALU_SQRT_EN to compile in the CORDIC (sqrt/atan2) datapath.
module share_superalu #(
    parameter int MAX_WIDTH   = 13,
    parameter int MUL_A_W     = 9,
    parameter int MUL_B_W     = 8,
    parameter int DIV_W       = 12,
    parameter int QUO_W       = 9,
    parameter int CORDIC_ITER = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [MAX_WIDTH-1:0] X_IN,
    input  logic [MAX_WIDTH-1:0] Y_IN,
    input  logic                 alu_start,
    input  logic [2:0]           alu_type,
    input  logic [1:0]           mode_type,
    input  logic [9:0]           OFFSET,
    output logic [MAX_WIDTH-1:0] FOUT,
    output logic [MAX_WIDTH-1:0] POUT,
    output logic                 alu_is_done
);
    localparam int ACC_W  = MUL_A_W + MUL_B_W;
    localparam int DIV_NW = DIV_W + QUO_W;
    localparam int CNT_W  = $clog2(CORDIC_ITER + QUO_W + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_POST, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_SQRT} op_t;

    state_t               state_reg;
    op_t                  op_reg;
    logic [1:0]           mode_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [MAX_WIDTH-1:0] fout_reg;
    logic [MAX_WIDTH-1:0] pout_reg;
    logic                 done_reg;

    logic [MUL_A_W-1:0]   mul_a_reg;
    logic [MUL_B_W-1:0]   mul_b_reg;
    logic [ACC_W-1:0]     mul_ash_reg;
    logic [ACC_W-1:0]     mul_acc_reg;

    logic [DIV_NW-1:0]    div_rem_reg;
    logic [DIV_NW-1:0]    div_dv_reg;
    logic [QUO_W-1:0]     div_q_reg;
    logic                 div_ovf_reg;

    logic [DIV_NW-1:0]    div_n_ext;
    logic [DIV_NW-1:0]    div_num;
    logic [DIV_NW-1:0]    div_lim;
    logic [DIV_NW-1:0]    div_dv_init;

    assign FOUT        = fout_reg;
    assign POUT        = pout_reg;
    assign alu_is_done = done_reg;

    // Scaled numerator; the quotient fits QUO_W bits only when num < d << QUO_W,
    // which also catches d = 0.
    always_comb begin
        div_n_ext = DIV_NW'(X_IN[DIV_W-1:0]);
        case (mode_type)
            2'b01:   div_num = div_n_ext << (QUO_W - 2);
            2'b10:   div_num = div_n_ext << (QUO_W - 3);
            default: div_num = div_n_ext << (QUO_W - 1);
        endcase
        div_lim     = {Y_IN[DIV_W-1:0], {QUO_W{1'b0}}};
        div_dv_init = DIV_NW'(Y_IN[DIV_W-1:0]) << (QUO_W - 1);
    end

`ifdef SUPERALU_SQRT_EN
    localparam int CW = 16;
    localparam int GW = CW + 11;
    localparam logic [10:0] GAIN = 11'd1243;

    logic signed [CW-1:0] cx_reg;
    logic signed [CW-1:0] cy_reg;
    logic signed [CW-1:0] cx_sh;
    logic signed [CW-1:0] cy_sh;
    logic [MAX_WIDTH-1:0] cz_reg;
    logic [MAX_WIDTH-1:0] mag_reg;
    logic [9:0]           off_reg;
    logic [CNT_W-1:0]     cor_shamt;
    logic [GW-1:0]        gain_part [0:11];

    // Step 0 of the iteration phase is the pre-rotation, so micro-rotation i runs at cnt = i+1.
    assign cor_shamt = cnt_reg - CNT_W'(1);
    assign cx_sh     = cx_reg >>> cor_shamt;
    assign cy_sh     = cy_reg >>> cor_shamt;

    assign gain_part[0] = '0;
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_gain
            assign gain_part[gi+1] = gain_part[gi] +
                (GAIN[gi] ? (GW'($unsigned(cx_reg)) << gi) : GW'(0));
        end
    endgenerate

    function automatic logic [MAX_WIDTH-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        case (int'(idx))
            0:       atan_lut = 13'd1024;
            1:       atan_lut = 13'd604;
            2:       atan_lut = 13'd319;
            3:       atan_lut = 13'd162;
            4:       atan_lut = 13'd81;
            5:       atan_lut = 13'd41;
            6:       atan_lut = 13'd20;
            7:       atan_lut = 13'd10;
            8:       atan_lut = 13'd5;
            9:       atan_lut = 13'd3;
            10:      atan_lut = 13'd1;
            11:      atan_lut = 13'd1;
            default: atan_lut = 13'd0;
        endcase
    endfunction
`else
    logic unused_sqrt_inputs;
    assign unused_sqrt_inputs = ^{X_IN[MAX_WIDTH-1:DIV_W], Y_IN[MAX_WIDTH-1:DIV_W], OFFSET};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_MUL;
            mode_reg    <= '0;
            cnt_reg     <= '0;
            fout_reg    <= '0;
            pout_reg    <= '0;
            done_reg    <= 1'b0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            mul_ash_reg <= '0;
            mul_acc_reg <= '0;
            div_rem_reg <= '0;
            div_dv_reg  <= '0;
            div_q_reg   <= '0;
            div_ovf_reg <= 1'b0;
`ifdef SUPERALU_SQRT_EN
            cx_reg      <= '0;
            cy_reg      <= '0;
            cz_reg      <= '0;
            mag_reg     <= '0;
            off_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (alu_start && alu_type != 3'b000) begin
                        state_reg <= S_LOAD;
                        if (alu_type[2])      op_reg <= OP_MUL;
                        else if (alu_type[1]) op_reg <= OP_DIV;
                        else                  op_reg <= OP_SQRT;
                    end
                end
                S_LOAD: begin
                    mode_reg    <= mode_type;
                    cnt_reg     <= '0;
                    mul_a_reg   <= X_IN[MUL_A_W-1:0];
                    mul_b_reg   <= Y_IN[MUL_B_W-1:0];
                    mul_ash_reg <= ACC_W'(X_IN[MUL_A_W-1:0]);
                    mul_acc_reg <= '0;
                    div_rem_reg <= div_num;
                    div_dv_reg  <= div_dv_init;
                    div_q_reg   <= '0;
                    div_ovf_reg <= (div_num >= div_lim);
`ifdef SUPERALU_SQRT_EN
                    cx_reg      <= CW'($signed(X_IN));
                    cy_reg      <= CW'($signed(Y_IN));
                    cz_reg      <= '0;
                    off_reg     <= OFFSET;
                    state_reg   <= S_ITER;
`else
                    if (op_reg == OP_SQRT) begin
                        fout_reg  <= '0;
                        pout_reg  <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_ITER;
                    end
`endif
                end
                S_ITER: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    case (op_reg)
                        OP_MUL: begin
                            if (mul_b_reg[0])
                                mul_acc_reg <= mul_acc_reg + mul_ash_reg;
                            mul_ash_reg <= mul_ash_reg << 1;
                            mul_b_reg   <= mul_b_reg >> 1;
                            if (cnt_reg == CNT_W'(MUL_B_W - 1)) begin
                                cnt_reg   <= '0;
                                state_reg <= S_POST;
                            end
                        end
                        OP_DIV: begin
                            if (div_rem_reg >= div_dv_reg) begin
                                div_rem_reg <= div_rem_reg - div_dv_reg;
                                div_q_reg   <= {div_q_reg[QUO_W-2:0], 1'b1};
                            end else begin
                                div_q_reg   <= {div_q_reg[QUO_W-2:0], 1'b0};
                            end
                            div_dv_reg <= div_dv_reg >> 1;
                            if (cnt_reg == CNT_W'(QUO_W - 1)) begin
                                cnt_reg   <= '0;
                                state_reg <= S_POST;
                            end
                        end
                        default: begin
`ifdef SUPERALU_SQRT_EN
                            if (cnt_reg == '0) begin
                                // +4096 and -4096 share one encoding modulo 2^13.
                                if (cx_reg[CW-1]) begin
                                    cx_reg <= -cx_reg;
                                    cy_reg <= -cy_reg;
                                    cz_reg <= 13'h1000;
                                end
                            end else if (!cy_reg[CW-1]) begin
                                cx_reg <= cx_reg + cy_sh;
                                cy_reg <= cy_reg - cx_sh;
                                cz_reg <= cz_reg + atan_lut(cor_shamt);
                            end else begin
                                cx_reg <= cx_reg - cy_sh;
                                cy_reg <= cy_reg + cx_sh;
                                cz_reg <= cz_reg - atan_lut(cor_shamt);
                            end
                            if (cnt_reg == CNT_W'(CORDIC_ITER)) begin
                                cnt_reg   <= '0;
                                state_reg <= S_POST;
                            end
`else
                            cnt_reg   <= '0;
                            state_reg <= S_POST;
`endif
                        end
                    endcase
                end
                S_POST: begin
                    case (op_reg)
                        OP_MUL: begin
                            case (mode_reg)
                                2'b00:   fout_reg <= MAX_WIDTH'(mul_acc_reg >> MUL_B_W);
                                2'b01:   fout_reg <= MAX_WIDTH'(mul_a_reg) +
                                                     MAX_WIDTH'(mul_acc_reg >> MUL_B_W);
                                2'b11:   fout_reg <= MAX_WIDTH'({mul_a_reg, 1'b0});
                                default: fout_reg <= MAX_WIDTH'(mul_a_reg);
                            endcase
                            pout_reg  <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                        OP_DIV: begin
                            fout_reg  <= div_ovf_reg ? MAX_WIDTH'({QUO_W{1'b1}})
                                                     : MAX_WIDTH'(div_q_reg);
                            pout_reg  <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                        default: begin
`ifdef SUPERALU_SQRT_EN
                            // Two post cycles: rounded gain compensation, then offset removal.
                            if (cnt_reg == '0) begin
                                mag_reg <= MAX_WIDTH'((gain_part[11] + GW'(1024)) >> 11);
                                cnt_reg <= CNT_W'(1);
                            end else begin
                                if (mag_reg > MAX_WIDTH'(off_reg))
                                    fout_reg <= mag_reg - MAX_WIDTH'(off_reg);
                                else
                                    fout_reg <= '0;
                                pout_reg  <= cz_reg;
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end
`else
                            fout_reg  <= '0;
                            pout_reg  <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
`endif
                        end
                    endcase
                end
                S_DONE: begin
                    if (!alu_start) begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_share_superalu.sv
// Table-driven scoreboard bench for share_superalu: multiply, divide, sqrt, handshake and reset.
module tb_share_superalu;
    logic        CLK = 1'b0;
    logic        RST;
    logic [12:0] X_IN, Y_IN;
    logic        alu_start;
    logic [2:0]  alu_type;
    logic [1:0]  mode_type;
    logic [9:0]  OFFSET;
    logic [12:0] FOUT, POUT;
    logic        alu_is_done;

    always #5 CLK = ~CLK;

    share_superalu dut (
        .CLK(CLK), .RST(RST), .X_IN(X_IN), .Y_IN(Y_IN),
        .alu_start(alu_start), .alu_type(alu_type), .mode_type(mode_type),
        .OFFSET(OFFSET), .FOUT(FOUT), .POUT(POUT), .alu_is_done(alu_is_done)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [1:0]  mode;
        logic [12:0] x;
        logic [12:0] y;
        logic [9:0]  off;
        int          ef, tf, ep, tp, lmin, lmax;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(input int typ, input int mode, input int x, input int y,
                                input int off, input int ef, input int tf, input int ep,
                                input int tp, input int lmin, input int lmax);
        vec_t v;
        v.typ = 3'(typ); v.mode = 2'(mode); v.x = 13'(x); v.y = 13'(y); v.off = 10'(off);
        v.ef = ef; v.tf = tf; v.ep = ep; v.tp = tp; v.lmin = lmin; v.lmax = lmax;
        return v;
    endfunction

    // Counts edges after edge 0 until done; scrambles inputs once LOAD has latched them.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 64) begin
            @(posedge CLK);
            #1;
            lat++;
            if (alu_is_done) break;
            if (lat == 1) begin
                X_IN = 13'($urandom); Y_IN = 13'($urandom);
                mode_type = 2'($urandom); OFFSET = 10'($urandom);
                alu_type = 3'($urandom);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        X_IN = v.x; Y_IN = v.y; alu_type = v.typ; mode_type = v.mode; OFFSET = v.off;
        alu_start = 1'b1;
        sb_q.push_back(v);
    endtask

    task automatic check_result(input string tag, input int lat);
        vec_t e;
        e = sb_q.pop_front();
        chk({tag, " done"}, int'(alu_is_done), 1, 1);
        chk({tag, " latency"}, lat, e.lmin, e.lmax);
        chk({tag, " fout"}, int'(FOUT), e.ef - e.tf, e.ef + e.tf);
        chk({tag, " pout"}, int'($signed(POUT)), e.ep - e.tp, e.ep + e.tp);
        $display("%s: fout=%0d pout=%0d lat=%0d", tag, FOUT, $signed(POUT), lat);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        drive(v);
        @(posedge CLK);
        wait_done(lat);
        check_result(tag, lat);
        @(posedge CLK); #1;
        chk({tag, " hold done"}, int'(alu_is_done), 1, 1);
        chk({tag, " hold fout"}, int'(FOUT), v.ef - v.tf, v.ef + v.tf);
        @(negedge CLK);
        alu_start = 1'b0;
        @(posedge CLK); #1;
        chk({tag, " done clear"}, int'(alu_is_done), 0, 0);
        chk({tag, " fout kept"}, int'(FOUT), v.ef - v.tf, v.ef + v.tf);
    endtask

    localparam int MUL = 4, DIV = 2, SQ = 1;

    initial begin
        int   lat;
        vec_t v;

        vecs.push_back(mk(MUL, 0, 240, 107, 0, 100, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 1, 240, 107, 0, 340, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 3, 7, 0, 0, 14, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 2, 300, 5, 0, 300, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 1, 511, 255, 0, 1020, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 3, 511, 255, 0, 1022, 0, 0, 0, 10, 10));
        vecs.push_back(mk(MUL, 0, 'h1F00, 'h1F80, 0, 128, 0, 0, 0, 10, 10));
        vecs.push_back(mk(DIV, 1, 42, 27, 0, 199, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 2, 142, 270, 0, 33, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 42, 170, 0, 63, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 42, 30, 0, 358, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 3, 42, 30, 0, 358, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 4000, 1, 0, 511, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 100, 0, 0, 511, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 510, 256, 0, 510, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 0, 512, 256, 0, 511, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 2, 4095, 4095, 0, 64, 0, 0, 0, 11, 11));
        vecs.push_back(mk(DIV, 2, 7, 3, 0, 149, 0, 0, 0, 11, 11));
        vecs.push_back(mk(7, 0, 240, 107, 0, 100, 0, 0, 0, 10, 10));
        vecs.push_back(mk(3, 0, 42, 30, 0, 358, 0, 0, 0, 11, 11));
`ifdef SUPERALU_SQRT_EN
        vecs.push_back(mk(SQ, 0, 58, 50, 0, 76, 1, 928, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, -58, 50, 0, 76, 1, 3168, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, 58, -50, 0, 76, 1, -928, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, -58, -50, 0, 76, 1, -3168, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, 50, 58, 0, 76, 1, 1120, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, 58, 50, 10, 66, 1, 928, 3, 16, 16));
        vecs.push_back(mk(SQ, 0, 58, 50, 100, 0, 0, 928, 3, 16, 16));
`else
        vecs.push_back(mk(SQ, 0, 58, 50, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(SQ, 2, -58, -50, 10, 0, 0, 0, 0, 1, 2));
`endif

        RST = 1'b1; alu_start = 1'b0; alu_type = 3'b000; mode_type = 2'b00;
        X_IN = '0; Y_IN = '0; OFFSET = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset fout", int'(FOUT), 0, 0);
        chk("reset pout", int'(POUT), 0, 0);
        chk("reset done", int'(alu_is_done), 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // alu_type = 0 must never start an operation.
        @(negedge CLK);
        alu_type = 3'b000; X_IN = 13'd99; Y_IN = 13'd1; alu_start = 1'b1;
        repeat (14) @(posedge CLK);
        #1;
        chk("type0 done", int'(alu_is_done), 0, 0);
        chk("type0 fout", int'(FOUT), vecs[vecs.size()-1].ef - vecs[vecs.size()-1].tf,
            vecs[vecs.size()-1].ef + vecs[vecs.size()-1].tf);
        @(negedge CLK);
        alu_start = 1'b0;

        // Start pulse shorter than the operation: DONE lasts exactly one cycle.
        @(negedge CLK);
        drive(mk(MUL, 1, 240, 107, 0, 340, 0, 0, 0, 10, 10));
        @(posedge CLK);
        @(negedge CLK);
        alu_start = 1'b0;
        wait_done(lat);
        check_result("early_drop", lat);
        @(posedge CLK); #1;
        chk("early_drop one-cycle done", int'(alu_is_done), 0, 0);

        // Reset in the middle of a divide aborts it.
        @(negedge CLK);
        drive(mk(DIV, 0, 42, 30, 0, 358, 0, 0, 0, 11, 11));
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1; alu_start = 1'b0;
        @(posedge CLK); #1;
        v = sb_q.pop_front();
        chk("midrst fout", int'(FOUT), 0, 0);
        chk("midrst pout", int'(POUT), 0, 0);
        chk("midrst done", int'(alu_is_done), 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        chk("midrst aborted", int'(alu_is_done), 0, 0);
        $display("midrst: aborted divide %0d/%0d", v.x, v.y);
        run_vec(mk(DIV, 1, 42, 27, 0, 199, 0, 0, 0, 11, 11), 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/share_superalu.md
# share_superalu

Shared multi-cycle arithmetic unit providing fixed-point multiply, fixed-point divide, and a CORDIC magnitude/phase unit (sqrt(X²+Y²) and atan2) over one iterative datapath. It sits beside the control CPU and the simulated-annealing/calibration logic, which use it for scaling, ratio and vector-magnitude computations. Only one operation is in flight at a time.

## Interface
Parameters:
- MAX_WIDTH, 13: operand/result bus width.
- MUL_A_W, 9: multiplicand width.
- MUL_B_W, 8: multiplier width.
- DIV_W, 12: dividend/divisor width.
- QUO_W, 9: quotient width.
- CORDIC_ITER, 12: CORDIC micro-rotations.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous and active-high.
- X_IN  in  13  operand A (multiplicand / dividend / signed X).
- Y_IN  in  13  operand B (multiplier / divisor / signed Y).
- alu_start  in  1  level request; operation begins when sampled high in IDLE.
- alu_type  in  3  {mult, div, sqrt}, one-hot.
- mode_type  in  2  per-operation scaling mode.
- OFFSET  in  10  unsigned magnitude offset (sqrt only).
- FOUT  out  13  result (product / quotient / magnitude), zero-extended.
- POUT  out  13  signed phase (sqrt only; 0 otherwise).
- alu_is_done  out  1  result valid.

## Operation
- FSM states: IDLE, LOAD, ITER, POST, DONE.
- IDLE → LOAD when alu_start=1 and alu_type≠0. Operands and mode are latched in LOAD.
- If alu_type is not one-hot, priority is mult > div > sqrt. If alu_type=0, the FSM stays in IDLE.
- DONE holds alu_is_done=1 and keeps FOUT/POUT stable while alu_start=1.
- DONE → IDLE on the first cycle alu_start=0. alu_is_done clears in that transition.
- A new operation therefore requires alu_start to go low then high. Results stay on FOUT/POUT until the next LOAD.
- Multiply (shift-add, 8 iterations). a=X_IN[8:0], b=Y_IN[7:0]. The result is 12 bits in FOUT[11:0]; FOUT[12]=0.
  - mode 00: floor(a·b/256).
  - mode 01: floor(a·(256+b)/256).
  - mode 11: a<<1.
  - mode 10: a, passed through.
- Divide (restoring, 9 quotient bits). n=X_IN[11:0], d=Y_IN[11:0]. The quotient is in FOUT[8:0].
  - mode 00: floor(n·256/d).
  - mode 01: floor(n·128/d).
  - mode 10: floor(n·64/d).
  - mode 11: same as 00.
  - If the true quotient exceeds 511, or d=0, the result saturates to 511.
- Sqrt (CORDIC vectoring). X and Y are 13-bit two's complement.
  - Pre-rotation: if X<0, negate both X and Y and set the phase accumulator to +4096 for Y≥0, or −4096 for Y<0. The phase accumulator wraps modulo 2^13.
  - Internal datapath is 16 bits signed to prevent overflow.
  - After the iterations, the magnitude is multiplied by the gain compensation 1243/2048 (≈0.607) using shift-add, then rounded.
  - OFFSET is then subtracted, saturating at 0.
  - POUT scale: π ↔ 4096 LSB; range −4096..4095.

## Timing
- Reset: FSM=IDLE, FOUT=0, POUT=0, alu_is_done=0.
- Reset asserted mid-operation aborts the operation with the same reset values.
- Latency from the edge that samples alu_start=1 in IDLE to the first cycle alu_is_done=1:
  - multiply: 10 cycles.
  - divide: 11 cycles.
  - sqrt: 16 cycles.
- Inputs are ignored after LOAD. Changing X_IN/Y_IN/mode mid-operation has no effect.
- alu_start dropping before DONE does not abort the operation. In that case DONE lasts exactly one cycle, then the FSM returns to IDLE.

## Configuration
- SUPERALU_SQRT_EN defined: the CORDIC datapath is compiled in, as described above.
- SUPERALU_SQRT_EN undefined: the CORDIC logic is removed.
  - A sqrt request goes LOAD → DONE with FOUT=0 and POUT=0, and alu_is_done rises 2 cycles after start.
  - Multiply and divide behaviour is unchanged.

## Test plan
- Multiply, X=240, Y=107:
  - mode 00 → FOUT=100.
  - mode 01 → FOUT=340.
  - Both with alu_is_done at +10 cycles.
- Multiply mode 11, X=7 → FOUT=14. Then drop and re-raise alu_start: alu_is_done falls for at least one cycle and a second result appears.
- Divide, each checked against the floor value:
  - 42/27 mode 01 → 199.
  - 142/270 mode 10 → 33.
  - 42/170 mode 00 → 63.
  - 42/30 mode 00 → 358.
  - 4000/1 mode 00 → 511 (saturation).
  - d=0 → 511.
- Sqrt with OFFSET=0; FOUT=76±1 in all cases:
  - (58,50) → POUT=928±3.
  - (−58,50) → POUT=3168±3.
  - (58,−50) → POUT=−928±3.
  - (−58,−50) → POUT=−3168±3.
  - (50,58) → POUT=1120±3.
- Sqrt (58,50) with OFFSET=10 → FOUT=66±1. With OFFSET=100 → FOUT=0.
- Assert RST mid-divide → next cycle FOUT=0, POUT=0, alu_is_done=0, FSM in IDLE. A subsequent operation completes correctly.
